// File: rtl/goose_sprite_engine.sv
// ============================================================================
// Module      : goose_sprite_engine
// Description : Scaled, animated, bouncing sprite placed on the VGA raster;
//               emits a 2-cycle pipelined palette index and opaque flag.
//               Optional macro GOOSE_MIRROR_EN mirrors columns while moving left.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module goose_sprite_engine #(
    parameter int SRC_LOG2   = 5,
    parameter int SCALE_LOG2 = 3,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6,
    parameter int IDX_W      = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    localparam int FRAME_W   = $clog2(NUM_FRAMES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                video_active,
    input  logic                frame_tick,
    input  logic                play,
    input  logic                rewind,
    input  logic                move_en,
    input  logic [1:0]          speed,
    output logic [FRAME_W-1:0]  rom_frame,
    output logic [SRC_LOG2-1:0] rom_x,
    output logic [SRC_LOG2-1:0] rom_y,
    input  logic [IDX_W-1:0]    rom_pixel,
    output logic [IDX_W-1:0]    px_index,
    output logic                px_opaque,
    output logic [FRAME_W-1:0]  anim_frame,
    output logic [9:0]          pos_x,
    output logic [9:0]          pos_y
);

    localparam int          HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [10:0] C_SPR_S  = 11'(1 << (SRC_LOG2 + SCALE_LOG2));
    localparam logic [10:0] C_MAX_X  = 11'(H_ACTIVE) - C_SPR_S;
    localparam logic [10:0] C_MAX_Y  = 11'(V_ACTIVE) - C_SPR_S;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } anim_state_t;

    anim_state_t         r_state, w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [FRAME_W-1:0]  w_frame_nxt;
    logic                r_dir_x, r_dir_y;
    logic                r_in_spr_d;

    // Returns {direction, position}; direction 1 means moving toward zero.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [1:0] spd, input logic [10:0] max);
        logic signed [10:0] cand;
        cand = dir ? ($signed({1'b0, pos}) - $signed({9'd0, spd}))
                   : ($signed({1'b0, pos}) + $signed({9'd0, spd}));
        if (cand > $signed(max))
            return {~dir, max[9:0]};
        else if (cand < 11'sd0)
            return {~dir, 10'd0};
        else
            return {dir, cand[9:0]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            anim_frame <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            anim_frame <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_frame_nxt = anim_frame;
        if (rewind) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
            w_frame_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_hold_nxt  = '0;
                    w_frame_nxt = '0;
                    if (play) w_state_nxt = PLAY;
                end
                PLAY: begin
                    if (frame_tick) begin
                        if (r_hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
                            w_hold_nxt  = '0;
                            w_frame_nxt = (anim_frame == FRAME_W'(NUM_FRAMES - 1))
                                          ? '0 : anim_frame + 1'b1;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                    if (!play) w_state_nxt = PAUSE;
                end
                PAUSE: begin
                    if (play) w_state_nxt = PLAY;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x   <= '0;
            pos_y   <= '0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (frame_tick && move_en && (speed != 2'd0)) begin
            {r_dir_x, pos_x} <= axis_step(pos_x, r_dir_x, speed, C_MAX_X);
            {r_dir_y, pos_y} <= axis_step(pos_y, r_dir_y, speed, C_MAX_Y);
        end
    end

    logic [10:0]         w_dx, w_dy;
    logic                w_in_spr;
    logic [SRC_LOG2-1:0] w_lx, w_ly, w_rom_x;

    always_comb begin
        w_dx     = {1'b0, pix_x} - {1'b0, pos_x};
        w_dy     = {1'b0, pix_y} - {1'b0, pos_y};
        w_in_spr = video_active
                   && ({1'b0, pix_x} >= {1'b0, pos_x}) && ({1'b0, pix_x} < ({1'b0, pos_x} + C_SPR_S))
                   && ({1'b0, pix_y} >= {1'b0, pos_y}) && ({1'b0, pix_y} < ({1'b0, pos_y} + C_SPR_S));
        w_lx     = SRC_LOG2'(w_dx >> SCALE_LOG2);
        w_ly     = SRC_LOG2'(w_dy >> SCALE_LOG2);
`ifdef GOOSE_MIRROR_EN
        w_rom_x  = r_dir_x ? ~w_lx : w_lx;
`else
        w_rom_x  = w_lx;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_x      <= '0;
            rom_y      <= '0;
            rom_frame  <= '0;
            r_in_spr_d <= 1'b0;
            px_index   <= '0;
            px_opaque  <= 1'b0;
        end else begin
            rom_x      <= w_in_spr ? w_rom_x : '0;
            rom_y      <= w_in_spr ? w_ly : '0;
            rom_frame  <= anim_frame;
            r_in_spr_d <= w_in_spr;
            px_index   <= r_in_spr_d ? rom_pixel : '0;
            px_opaque  <= r_in_spr_d && (rom_pixel != '0);
        end
    end

endmodule

`default_nettype wire
